// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, default dwell,
// the (row, col) -> hex keymap and a one-hot to index helper.
package keypad_pkg;

   typedef enum logic {
      SCAN,
      HOLD
   } state_t;

   localparam int SCAN_DIV_DEFAULT = 48000;

   // Indexed {row_idx, col_idx}; entry 15 (row3, col3) is listed first.
   localparam logic [15:0][3:0] KEYMAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [1:0] low_index(input logic [3:0] active);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (active[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the 4 asynchronous keypad row lines.
// Resets to all-high so an idle keypad is seen during and after reset.
module sync2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] raw,
   output logic [3:0] synced
);

   logic [3:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta   <= 4'hF;
         synced <= 4'hF;
      end else begin
         meta   <= raw;
         synced <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, latches the first closure as a
// hex code and holds that column until release. KEYPAD_GHOST_REJECT_EN rejects multi-row closures.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_pressed
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [3:0]    rows_sync;
   logic [3:0]    row_low;
   logic [CW-1:0] dwell;
   logic          sample;
   logic          any_low;
   logic          press_ok;
   state_t        state, state_nxt;
   logic [3:0]    cols_nxt;
   logic [3:0]    code_nxt;
   logic          pressed_nxt;

   sync2 u_sync (
      .clk    (clk),
      .reset  (reset),
      .raw    (rows),
      .synced (rows_sync)
   );

   assign row_low = ~rows_sync;
   assign any_low = |row_low;
   assign sample  = (dwell == LAST);

`ifdef KEYPAD_GHOST_REJECT_EN
   // More than one row low in a column is ambiguous (possible ghosting): treat as idle.
   assign press_ok = any_low && ((row_low & (row_low - 4'd1)) == 4'd0);
`else
   assign press_ok = any_low;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         dwell <= '0;
      end else if (sample) begin
         dwell <= '0;
      end else begin
         dwell <= dwell + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SCAN;
         cols        <= 4'b1110;
         key_code    <= 4'h0;
         key_pressed <= 1'b0;
      end else begin
         state       <= state_nxt;
         cols        <= cols_nxt;
         key_code    <= code_nxt;
         key_pressed <= pressed_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cols_nxt    = cols;
      code_nxt    = key_code;
      pressed_nxt = key_pressed;
      case (state)
         SCAN: begin
            if (sample) begin
               if (press_ok) begin
                  code_nxt    = KEYMAP[{low_index(row_low), low_index(~cols)}];
                  pressed_nxt = 1'b1;
                  state_nxt   = HOLD;
               end else begin
                  cols_nxt = {cols[2:0], cols[3]};
               end
            end
         end
         HOLD: begin
            // Only a full release leaves HOLD; extra rows in this column never change the code.
            if (sample && !any_low) begin
               pressed_nxt = 1'b0;
               cols_nxt    = {cols[2:0], cols[3]};
               state_nxt   = SCAN;
            end
         end
         default: begin
            state_nxt = SCAN;
         end
      endcase
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from cols, and a timeline
// reference model predicts cols/key_pressed/key_code every cycle; directed scenarios plus random presses.
module tb_keypad_scanner;

   localparam int DIV = 8;
`ifdef KEYPAD_GHOST_REJECT_EN
   localparam bit GHOST = 1'b1;
`else
   localparam bit GHOST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  key_code;
   logic        key_pressed;
   logic [15:0] keys = '0;   // bit r*4+c: key at (row r, col c) held down

   int checks = 0;
   int errors = 0;

   int KMAP [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

   // Reference state: cycle position in the dwell, scanned column, held flag, code, row history.
   int         m_phase;
   int         m_col;
   bit         m_held;
   int         m_code;
   logic [3:0] m_h1, m_h2;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(DIV)) dut (
      .clk         (clk),
      .reset       (reset),
      .rows        (rows),
      .cols        (cols),
      .key_code    (key_code),
      .key_pressed (key_pressed)
   );

   // A closed key shorts its row to its column; a row reads low if any driven-low column reaches it.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++) begin
         rows[r] = ~|(keys[r*4 +: 4] & ~cols);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic [3:0] r_now, input logic rst);
      logic [3:0] lows;
      int n, low;
      if (rst) begin
         m_phase = 0; m_col = 0; m_held = 0; m_code = 0; m_h1 = 4'hF; m_h2 = 4'hF;
      end else begin
         lows = ~m_h2;
         n    = $countones(lows);
         low  = 0;
         for (int i = 3; i >= 0; i--) if (lows[i]) low = i;
         if (m_phase == DIV - 1) begin
            if (!m_held) begin
               if (n == 1 || (n > 1 && !GHOST)) begin
                  m_held = 1;
                  m_code = KMAP[low][m_col];
               end else begin
                  m_col = (m_col + 1) % 4;
               end
            end else if (n == 0) begin
               m_held = 0;
               m_col  = (m_col + 1) % 4;
            end
         end
         m_phase = (m_phase + 1) % DIV;
         m_h2 = m_h1;
         m_h1 = r_now;
      end
   endtask

   task automatic tick();
      logic [3:0] ec;
      @(negedge clk);
      model_step(rows, reset);
      @(posedge clk);
      #1;
      ec = ~(4'b0001 << m_col);
      check("cols", 32'(cols), 32'(ec));
      check("key_pressed", 32'(key_pressed), 32'(m_held));
      if (m_held) check("key_code", 32'(key_code), 32'(m_code));
   endtask

   task automatic wait_pressed(input logic want, input int bound, input string tag, output int n);
      n = 0;
      while (key_pressed !== want && n < bound) begin
         tick();
         n++;
      end
      check(tag, 32'(key_pressed), 32'(want));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n, seen, r, c, r2;

      // Reset and idle rotation
      reset = 1'b1;
      ticks(3);
      reset = 1'b0;
      check("rst_cols", 32'(cols), 32'(4'b1110));
      check("rst_pressed", 32'(key_pressed), 32'(1'b0));
      check("rst_code", 32'(key_code), 32'(4'h0));
      ticks(DIV); check("rot1", 32'(cols), 32'(4'b1101));
      ticks(DIV); check("rot2", 32'(cols), 32'(4'b1011));
      ticks(DIV); check("rot3", 32'(cols), 32'(4'b0111));
      ticks(DIV); check("rot4", 32'(cols), 32'(4'b1110));

      // Single press of "5" (row1, col1)
      keys = 16'h1 << 5;
      wait_pressed(1'b1, 4 * DIV + 4, "press5_detect", n);
      check("press5_code", 32'(key_code), 32'(4'h5));
      check("press5_cols", 32'(cols), 32'(4'b1101));
      ticks(3 * DIV);
      check("press5_hold", 32'(key_pressed), 32'(1'b1));

      // Release of "5"
      keys = '0;
      wait_pressed(1'b0, 2 + DIV + 2, "rel5_detect", n);
      check("rel5_latency", 32'(n <= 2 + DIV), 32'(1));
      check("rel5_cols", 32'(cols), 32'(4'b1011));

      // Rows 0 and 2 low on col3
      keys = (16'h1 << 3) | (16'h1 << 11);
      if (GHOST) begin
         seen = 0;
         for (int i = 0; i < 6 * DIV; i++) begin
            tick();
            if (key_pressed) seen++;
         end
         check("ghost_no_press", 32'(seen), 32'(0));
      end else begin
         wait_pressed(1'b1, 4 * DIV + 4, "multi_detect", n);
         check("multi_code", 32'(key_code), 32'(4'hA));
      end
      keys = '0;
      wait_pressed(1'b0, 2 + DIV + 2, "multi_release", n);

      // Reset while holding "0" (row3, col1)
      keys = 16'h1 << 13;
      wait_pressed(1'b1, 4 * DIV + 4, "press0_detect", n);
      check("press0_code", 32'(key_code), 32'(4'h0));
      ticks(3);
      reset = 1'b1;
      keys  = '0;
      tick();
      check("midhold_cols", 32'(cols), 32'(4'b1110));
      check("midhold_pressed", 32'(key_pressed), 32'(1'b0));
      check("midhold_code", 32'(key_code), 32'(4'h0));
      reset = 1'b0;

      // "E" (row3, col0) pressed while col2 is driven
      n = 0;
      while (cols !== 4'b1011 && n < 5 * DIV) begin
         tick();
         n++;
      end
      check("reach_col2", 32'(cols), 32'(4'b1011));
      keys = 16'h1 << 12;
      wait_pressed(1'b1, 4 * DIV + 4, "pressE_detect", n);
      check("pressE_code", 32'(key_code), 32'(4'hE));
      check("pressE_cols", 32'(cols), 32'(4'b1110));
      check("pressE_wait", 32'(n >= DIV), 32'(1));
      keys = '0;
      wait_pressed(1'b0, 2 + DIV + 2, "relE_detect", n);

      // Random presses, blips, multi-row closures and occasional resets
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         keys = 16'h1 << (r * 4 + c);
         if ($urandom_range(0, 3) == 0) begin
            r2 = $urandom_range(0, 3);
            keys = keys | (16'h1 << (r2 * 4 + c));
         end
         ticks($urandom_range(1, 6 * DIV));
         if ($urandom_range(0, 9) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
         keys = '0;
         ticks($urandom_range(1, 4 * DIV));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
